// File: rtl/nibble_serial_add_ctrl.sv
// Nibble-serial add/subtract controller that time-multiplexes one external 4-bit adder,
// least-significant nibble first, with carry rippled through a register.

module bit4_parallel_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in,
  output logic [3:0] sum,
  output logic       c_out
);
  assign {c_out, sum} = {1'b0, a} + {1'b0, b} + {4'b0000, c_in};
endmodule

module nibble_serial_add_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4*NIBBLES-1:0]   in_a,
  input  logic [4*NIBBLES-1:0]   in_b,
  input  logic                   in_cin,
  input  logic                   in_sub,
  output logic [3:0]             adder_a,
  output logic [3:0]             adder_b,
  output logic                   adder_cin,
  input  logic [3:0]             adder_sum,
  input  logic                   adder_cout,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*NIBBLES-1:0]   out_sum,
  output logic                   out_cout,
  output logic                   out_ovf,
  output logic                   busy
);

  localparam int WIDTH = 4 * NIBBLES;
  localparam int IDX_W = $clog2(NIBBLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_reg, b_reg, result, sum_reg;
  logic             carry, cout_reg, ovf_reg;
  logic [IDX_W-1:0] idx;
  logic [IDX_W+1:0] base;
  logic             last_step;

  assign base      = {idx, 2'b00};
  assign last_step = (idx == LAST_IDX);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    adder_a   = 4'h0;
    adder_b   = 4'h0;
    adder_cin = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        busy      = 1'b1;
        adder_a   = a_reg[base +: 4];
        adder_b   = b_reg[base +: 4];
        adder_cin = carry;
        if (last_step) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Subtraction is A + ~B + ~borrow, so the operand and carry are inverted once at acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg    <= '0;
      b_reg    <= '0;
      result   <= '0;
      sum_reg  <= '0;
      carry    <= 1'b0;
      cout_reg <= 1'b0;
      ovf_reg  <= 1'b0;
      idx      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg  <= in_a;
            b_reg  <= in_sub ? ~in_b : in_b;
            carry  <= in_sub ^ in_cin;
            idx    <= '0;
            result <= '0;
          end
        end
        RUN: begin
          result[base +: 4] <= adder_sum;
          carry             <= adder_cout;
          if (!last_step) idx <= idx + 1'b1;
          if (last_step) begin
            // Published result lives apart from the working register so it survives the next accept.
            sum_reg  <= {adder_sum, result[WIDTH-5:0]};
            cout_reg <= adder_cout;
            ovf_reg  <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) & (adder_sum[3] != a_reg[WIDTH-1]);
          end
        end
        default: ;
      endcase
    end
  end

  assign out_sum  = sum_reg;
  assign out_cout = cout_reg;
  assign out_ovf  = ovf_reg;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Directed bench for nibble_serial_add_ctrl with a real 4-bit adder and a result scoreboard.

module tb_nibble_serial_add_ctrl;

  localparam int NIBBLES = 4;
  localparam int WIDTH   = 4 * NIBBLES;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid, in_ready, in_cin, in_sub;
  logic [WIDTH-1:0] in_a, in_b;
  logic [3:0]       adder_a, adder_b, adder_sum;
  logic             adder_cin, adder_cout;
  logic             out_valid, out_ready, out_cout, out_ovf, busy;
  logic [WIDTH-1:0] out_sum;

  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  nibble_serial_add_ctrl #(.NIBBLES(NIBBLES)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
    .adder_a(adder_a), .adder_b(adder_b), .adder_cin(adder_cin),
    .adder_sum(adder_sum), .adder_cout(adder_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf),
    .busy(busy)
  );

  bit4_parallel_adder u_adder (
    .a(adder_a), .b(adder_b), .c_in(adder_cin),
    .sum(adder_sum), .c_out(adder_cout)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // Reference: plain integer add / subtract with borrow, signed overflow from operand signs.
  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic cin, input logic sub);
    exp_t e;
    int   ai, bi, r;
    ai = int'(a);
    bi = int'(b);
    if (!sub) begin
      r      = ai + bi + int'(cin);
      e.cout = (r >= (1 << WIDTH));
      e.sum  = r[WIDTH-1:0];
      e.ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (e.sum[WIDTH-1] != a[WIDTH-1]);
    end else begin
      r      = ai - bi - int'(cin);
      e.cout = (r >= 0);
      e.sum  = r[WIDTH-1:0];
      e.ovf  = (a[WIDTH-1] != b[WIDTH-1]) && (e.sum[WIDTH-1] != a[WIDTH-1]);
    end
    return e;
  endfunction

  task automatic accept(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic cin, input logic sub);
    int n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("in_ready_wait", {31'b0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_a = a; in_b = b; in_cin = cin; in_sub = sub;
    @(posedge clk); #1;
    in_valid = 1'b0;
    sb.push_back(model(a, b, cin, sub));
  endtask

  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic cin, input logic sub, input int hold, input bit poke);
    exp_t             e;
    logic [WIDTH-1:0] held;
    accept(a, b, cin, sub);
    for (int i = 0; i < NIBBLES; i++) begin
      check("run_busy", {31'b0, busy}, 32'd1);
      check("run_in_ready", {31'b0, in_ready}, 32'd0);
      check("run_out_valid", {31'b0, out_valid}, 32'd0);
      check("run_adder_a", {28'b0, adder_a}, {28'b0, a[4*i +: 4]});
      if (poke && i == 1) begin
        in_valid = 1'b1; in_a = 16'hABCD; in_b = 16'h1357; in_sub = 1'b1;
      end
      if (poke && i == 2) in_valid = 1'b0;
      @(posedge clk); #1;
    end
    check("latency_out_valid", {31'b0, out_valid}, 32'd1);
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check("out_sum", {16'b0, out_sum}, {16'b0, e.sum});
      check("out_cout", {31'b0, out_cout}, {31'b0, e.cout});
      check("out_ovf", {31'b0, out_ovf}, {31'b0, e.ovf});
    end
    held = out_sum;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_out_valid", {31'b0, out_valid}, 32'd1);
      check("hold_out_sum", {16'b0, out_sum}, {16'b0, held});
      check("hold_in_ready", {31'b0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("post_hs_out_valid", {31'b0, out_valid}, 32'd0);
    check("post_hs_in_ready", {31'b0, in_ready}, 32'd1);
    check("post_hs_out_sum", {16'b0, out_sum}, {16'b0, held});
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0;
    #12;
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_out_sum", {16'b0, out_sum}, 32'd0);
    check("rst_adder_a", {28'b0, adder_a}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op(16'h0005, 16'h000D, 1'b0, 1'b0, 0, 1'b0);
    run_op(16'h1234, 16'h0F0F, 1'b0, 1'b0, 0, 1'b1);
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 3, 1'b0);
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0, 1'b0);
    run_op(16'h0005, 16'h0003, 1'b0, 1'b1, 0, 1'b0);
    run_op(16'h0003, 16'h0005, 1'b0, 1'b1, 0, 1'b0);
    run_op(16'h8000, 16'h0001, 1'b0, 1'b1, 0, 1'b0);
    run_op(16'h0010, 16'h0001, 1'b1, 1'b1, 0, 1'b0);

    // Abort in the second RUN cycle with an asynchronous reset between edges.
    accept(16'h4321, 16'h1111, 1'b0, 1'b0);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("abort_out_valid", {31'b0, out_valid}, 32'd0);
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_in_ready", {31'b0, in_ready}, 32'd1);
    check("abort_adder_bus", {23'b0, adder_a, adder_b, adder_cin}, 32'd0);
    check("abort_out_sum", {16'b0, out_sum}, 32'd0);
    void'(sb.pop_back());
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_op(16'h1111, 16'h2222, 1'b0, 1'b0, 1, 1'b0);

    check("scoreboard_drained", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
